// File: rtl/wt_dcache_rd_arb_if.sv
// Read-port bundles: per-controller side and single memory side.
interface wt_dcache_rd_arb_if #(
  parameter int NumPorts  = 3,
  parameter int IdxWidth  = 6,
  parameter int OffWidth  = 4,
  parameter int TagWidth  = 44,
  parameter int Ways      = 4,
  parameter int DataWidth = 64
);
  logic [NumPorts-1:0]          req;
  logic [NumPorts*IdxWidth-1:0] idx;
  logic [NumPorts*OffWidth-1:0] off;
  logic [NumPorts-1:0]          tag_only;
  logic [NumPorts*TagWidth-1:0] tag;
  logic [NumPorts-1:0]          ack;
  logic [NumPorts-1:0]          rvld;
  logic [DataWidth-1:0]         data;
  logic [Ways-1:0]              vld_bits;
  logic [Ways-1:0]              hit_oh;

  modport master (
    output req, idx, off, tag_only, tag,
    input  ack, rvld, data, vld_bits, hit_oh
  );
  modport slave (
    input  req, idx, off, tag_only, tag,
    output ack, rvld, data, vld_bits, hit_oh
  );
endinterface

interface wt_dcache_mem_rd_if #(
  parameter int IdxWidth  = 6,
  parameter int OffWidth  = 4,
  parameter int TagWidth  = 44,
  parameter int Ways      = 4,
  parameter int DataWidth = 64
);
  logic                 req;
  logic                 ack;
  logic [IdxWidth-1:0]  idx;
  logic [OffWidth-1:0]  off;
  logic                 tag_only;
  logic [TagWidth-1:0]  tag;
  logic [DataWidth-1:0] data;
  logic [Ways-1:0]      vld_bits;
  logic [Ways-1:0]      hit_oh;

  modport master (
    output req, idx, off, tag_only, tag,
    input  ack, data, vld_bits, hit_oh
  );
  modport slave (
    input  req, idx, off, tag_only, tag,
    output ack, data, vld_bits, hit_oh
  );
endinterface

// File: rtl/wt_dcache_rd_arb.sv
// Round-robin arbiter for the shared two-phase dcache read port.
// Optional starvation override: WT_DCACHE_RD_ARB_STARVE_EN.
module wt_dcache_rd_arb #(
  parameter int NumPorts  = 3,
  parameter int IdxWidth  = 6,
  parameter int OffWidth  = 4,
  parameter int TagWidth  = 44,
  parameter int Ways      = 4,
  parameter int DataWidth = 64,
  parameter int StarveThr = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_busy_i,
  wt_dcache_rd_arb_if.slave  rd_slv,
  wt_dcache_mem_rd_if.master mem_mst
);

  localparam int PtrW =
    (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef logic [PtrW-1:0] ptr_t;

  if (NumPorts < 1 || StarveThr < 1) begin : g_bad_cfg
    $error("wt_dcache_rd_arb: bad parameters");
  end

  ptr_t rr_ptr_q, rr_ptr_d;
  ptr_t gnt_q, gnt_d;
  ptr_t hold_idx_q, hold_idx_d;
  logic rvld_q, rvld_d;
  logic hold_q, hold_d;

  ptr_t g;
  logic found;
  int unsigned pidx;
  logic mem_req;
  logic acc;
  logic [NumPorts-1:0] ack_v;

`ifdef WT_DCACHE_RD_ARB_STARVE_EN
  localparam int CntW = $clog2(StarveThr + 1);

  logic [NumPorts-1:0][CntW-1:0] cnt_q, cnt_d;
  logic starve_hit;

  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!rd_slv.req[i] || ack_v[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CntW'(StarveThr)) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Grant selection: rr scan, then sticky hold, then starvation.
  always_comb begin
    g     = rr_ptr_q;
    found = 1'b0;
    pidx  = 0;
    for (int i = 0; i < NumPorts; i++) begin
      pidx = (int'(rr_ptr_q) + i) % NumPorts;
      if (!found && rd_slv.req[pidx]) begin
        g     = ptr_t'(pidx);
        found = 1'b1;
      end
    end
    if (hold_q && rd_slv.req[hold_idx_q]) begin
      g = hold_idx_q;
    end
`ifdef WT_DCACHE_RD_ARB_STARVE_EN
    starve_hit = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      if (!starve_hit && rd_slv.req[i] &&
          cnt_q[i] == CntW'(StarveThr)) begin
        g          = ptr_t'(i);
        starve_hit = 1'b1;
      end
    end
`endif
  end

  assign mem_req = (|rd_slv.req) & ~wr_busy_i & ~rst_i;
  assign acc     = mem_req & mem_mst.ack;

  always_comb begin
    ack_v = '0;
    if (acc) begin
      ack_v[g] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    rvld_d     = 1'b0;
    hold_d     = hold_q;
    hold_idx_d = hold_idx_q;
    if (hold_q && !rd_slv.req[hold_idx_q]) begin
      hold_d = 1'b0;
    end
    if (acc) begin
      rr_ptr_d = (int'(g) == NumPorts - 1) ?
                 '0 : g + ptr_t'(1);
      gnt_d    = g;
      rvld_d   = 1'b1;
      hold_d   = 1'b0;
    end else if (mem_req) begin
      hold_d     = 1'b1;
      hold_idx_d = g;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      rvld_q     <= 1'b0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      rvld_q     <= rvld_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

  always_comb begin
    mem_mst.req      = mem_req;
    mem_mst.idx      = '0;
    mem_mst.off      = '0;
    mem_mst.tag_only = 1'b0;
    mem_mst.tag      = '0;
    rd_slv.ack       = ack_v;
    rd_slv.rvld      = '0;
    rd_slv.data      = '0;
    rd_slv.vld_bits  = '0;
    rd_slv.hit_oh    = '0;
    if (mem_req) begin
      mem_mst.idx      = rd_slv.idx[g*IdxWidth +: IdxWidth];
      mem_mst.off      = rd_slv.off[g*OffWidth +: OffWidth];
      mem_mst.tag_only = rd_slv.tag_only[g];
    end
    // Cycle-1 phase: tag follows the port accepted last cycle.
    if (rvld_q && !rst_i) begin
      mem_mst.tag        = rd_slv.tag[gnt_q*TagWidth +: TagWidth];
      rd_slv.rvld[gnt_q] = 1'b1;
    end
    if (!rst_i) begin
      rd_slv.data     = mem_mst.data;
      rd_slv.vld_bits = mem_mst.vld_bits;
      rd_slv.hit_oh   = mem_mst.hit_oh;
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Scoreboard bench for wt_dcache_rd_arb (3 ports).
// Build with WT_DCACHE_RD_ARB_STARVE_EN for the starvation case.
module tb_wt_dcache_rd_arb;

  localparam int NP = 3;
  localparam int IW = 6;
  localparam int OW = 4;
  localparam int TW = 44;
  localparam int WY = 4;
  localparam int DW = 64;

  typedef struct {
    int            port;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy = 1'b0;

  logic [TW-1:0] tags [NP];
  logic [IW-1:0] idxs [NP];
  logic [OW-1:0] offs [NP];

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;

  wt_dcache_rd_arb_if #(
    .NumPorts(NP), .IdxWidth(IW), .OffWidth(OW),
    .TagWidth(TW), .Ways(WY), .DataWidth(DW)
  ) rd_bus ();

  wt_dcache_mem_rd_if #(
    .IdxWidth(IW), .OffWidth(OW),
    .TagWidth(TW), .Ways(WY), .DataWidth(DW)
  ) mem_bus ();

  wt_dcache_rd_arb #(
    .NumPorts(NP), .IdxWidth(IW), .OffWidth(OW),
    .TagWidth(TW), .Ways(WY), .DataWidth(DW),
    .StarveThr(2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_busy_i (busy),
    .rd_slv    (rd_bus.slave),
    .mem_mst   (mem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // One cycle: drive, check cycle-0 outputs, check any
  // due response, then queue the response this accept implies.
  task automatic cyc(input logic r,
                     input logic [NP-1:0] req,
                     input logic ack,
                     input logic bsy,
                     input logic [NP-1:0] exp_ack,
                     input int exp_g);
    exp_t e;
    @(negedge clk);
    rst              = r;
    busy             = bsy;
    rd_bus.req       = req;
    mem_bus.ack      = ack;
    mem_bus.data     = {$urandom, $urandom};
    mem_bus.vld_bits = WY'($urandom);
    mem_bus.hit_oh   = WY'(1) << $urandom_range(WY-1);
    if (r) sb.delete();
    #1;
    chk("ack", 64'(rd_bus.ack), 64'(exp_ack));
    chk("mem_req", 64'(mem_bus.req), 64'(exp_g >= 0));
    if (exp_g >= 0) begin
      chk("mem_idx", 64'(mem_bus.idx), 64'(idxs[exp_g]));
      chk("mem_off", 64'(mem_bus.off), 64'(offs[exp_g]));
      chk("tag_only", 64'(mem_bus.tag_only),
          64'(exp_g == 1));
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rvld", 64'(rd_bus.rvld), 64'(1) << e.port);
      chk("mem_tag", 64'(mem_bus.tag), 64'(e.tag));
      chk("hit_oh", 64'(rd_bus.hit_oh),
          64'(mem_bus.hit_oh));
      chk("data", rd_bus.data, mem_bus.data);
      chk("vld_bits", 64'(rd_bus.vld_bits),
          64'(mem_bus.vld_bits));
    end else begin
      chk("rvld_idle", 64'(rd_bus.rvld), 64'(0));
      chk("tag_idle", 64'(mem_bus.tag), 64'(0));
    end
    if (r) chk("rst_data", rd_bus.data, 64'(0));
    if (exp_ack != '0) begin
      e.port = exp_g;
      e.tag  = tags[exp_g];
      sb.push_back(e);
    end
  endtask

  initial begin
    tags[0] = 44'h111;
    tags[1] = 44'h222;
    tags[2] = 44'hABC;
    for (int p = 0; p < NP; p++) begin
      idxs[p] = IW'(5 + 21 * p);
      offs[p] = OW'(3 + p);
      rd_bus.idx[p*IW +: IW] = idxs[p];
      rd_bus.off[p*OW +: OW] = offs[p];
      rd_bus.tag[p*TW +: TW] = tags[p];
    end
    rd_bus.tag_only  = 3'b010;
    rd_bus.req       = '0;
    mem_bus.ack      = 1'b0;
    mem_bus.data     = '0;
    mem_bus.vld_bits = '0;
    mem_bus.hit_oh   = '0;

    // reset: everything quiet despite requests
    cyc(1, 3'b111, 1, 0, 3'b000, -1);
    cyc(1, 3'b111, 1, 0, 3'b000, -1);

    // all ports, mem always acks: 0,1,2,0
    cyc(0, 3'b111, 1, 0, 3'b001, 0);
    cyc(0, 3'b111, 1, 0, 3'b010, 1);
    cyc(0, 3'b111, 1, 0, 3'b100, 2);
    cyc(0, 3'b111, 1, 0, 3'b001, 0);

    // port 1 stalled 3 cycles, port 2 joins but must wait
    cyc(0, 3'b010, 0, 0, 3'b000, 1);
    cyc(0, 3'b110, 0, 0, 3'b000, 1);
    cyc(0, 3'b110, 0, 0, 3'b000, 1);
    cyc(0, 3'b110, 1, 0, 3'b010, 1);

    // accept port 2, then write busy: response still lands
    cyc(0, 3'b111, 1, 0, 3'b100, 2);
    cyc(0, 3'b111, 1, 1, 3'b000, -1);
    cyc(0, 3'b111, 1, 1, 3'b000, -1);
    cyc(0, 3'b111, 1, 0, 3'b001, 0);

    // hold on port 2 survives a busy cycle
    cyc(0, 3'b100, 0, 0, 3'b000, 2);
    cyc(0, 3'b111, 1, 1, 3'b000, -1);
    cyc(0, 3'b111, 1, 0, 3'b100, 2);

    // held port drops: arbitration restarts same cycle
    cyc(0, 3'b010, 0, 0, 3'b000, 1);
    cyc(0, 3'b001, 1, 0, 3'b001, 0);

    // reset right after an accept drops the response
    cyc(0, 3'b111, 1, 0, 3'b010, 1);
    cyc(1, 3'b111, 1, 0, 3'b000, -1);
    cyc(1, 3'b111, 1, 0, 3'b000, -1);
    cyc(0, 3'b111, 1, 0, 3'b001, 0);
    cyc(0, 3'b000, 0, 0, 3'b000, -1);
    cyc(0, 3'b000, 0, 0, 3'b000, -1);

    // port 2 waits two blocked cycles, port 0 only one
    cyc(1, 3'b000, 0, 0, 3'b000, -1);
    cyc(1, 3'b000, 0, 0, 3'b000, -1);
    cyc(0, 3'b100, 0, 1, 3'b000, -1);
    cyc(0, 3'b101, 0, 1, 3'b000, -1);
`ifdef WT_DCACHE_RD_ARB_STARVE_EN
    cyc(0, 3'b101, 1, 0, 3'b100, 2);
`else
    cyc(0, 3'b101, 1, 0, 3'b001, 0);
`endif
    cyc(0, 3'b000, 0, 0, 3'b000, -1);
    cyc(0, 3'b000, 0, 0, 3'b000, -1);

    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
